// File: rtl/arm7tdmi_cache_mem_arbiter.sv
// arm7tdmi_cache_mem_arbiter
// Shares one external memory port between the icache refill path and the
// dcache refill/write-back path. Round-robin arbitration, grant held for a
// whole transaction, optional bounded lock for line-fill bursts.
// Optional build macro: ARB_STATS_EN adds grant/conflict statistics outputs.
module arm7tdmi_cache_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // icache (read-only requester)
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_req,
    input  logic                  i_lock,
    output logic [31:0]           i_rdata,
    output logic                  i_ready,
    // dcache (read / write-back requester)
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_req,
    input  logic                  d_write,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_byte_en,
    input  logic                  d_lock,
    output logic [31:0]           d_rdata,
    output logic                  d_ready,
    // memory side
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_byte_en,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    // status
    output logic [1:0]            grant_owner,
    output logic                  arb_busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]           stat_i_grants,
    output logic [31:0]           stat_d_grants,
    output logic [31:0]           stat_conflicts
`endif
);

    // beat_cnt never exceeds MAX_BURST, so this width always holds cnt+1
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    // last_grant encoding: 0 = icache, 1 = dcache
    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] beat_inc;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       grant_owner_q, grant_owner_d;
    logic             arb_busy_q, arb_busy_d;
    logic             beat_done;
    logic             cur_lock;

    // Read data is broadcast; each consumer qualifies it with its ready
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Memory-side mux driven purely by the current owner; IDLE drives zeros
    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = '0;
        mem_write   = 1'b0;
        mem_wdata   = 32'd0;
        mem_byte_en = 4'd0;
        cur_lock    = 1'b0;
        case (state_q)
            ST_GNT_I: begin
                mem_req     = i_req;
                mem_addr    = i_addr;
                mem_byte_en = 4'b1111;
                cur_lock    = i_lock;
            end
            ST_GNT_D: begin
                mem_req     = d_req;
                mem_addr    = d_addr;
                mem_write   = d_write;
                mem_wdata   = d_wdata;
                mem_byte_en = d_byte_en;
                cur_lock    = d_lock;
            end
            default: ;
        endcase
    end

    // mem_ready without an outstanding request never completes a beat
    assign beat_done = mem_req & mem_ready;
    assign i_ready   = beat_done & (state_q == ST_GNT_I);
    assign d_ready   = beat_done & (state_q == ST_GNT_D);
    assign beat_inc  = beat_cnt_q + CNT_W'(1);

    // Arbitration, burst accounting and abort handling
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_grant_q == LG_I) ? ST_GNT_D : ST_GNT_I;
                end else if (i_req) begin
                    state_d = ST_GNT_I;
                end else if (d_req) begin
                    state_d = ST_GNT_D;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (beat_done) begin
                    last_grant_d = (state_q == ST_GNT_I) ? LG_I : LG_D;
                    if (cur_lock && (32'(beat_inc) < MAX_BURST)) begin
                        beat_cnt_d = beat_inc;
                    end else begin
                        beat_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end
                end else if (!mem_req) begin
                    // requester withdrew before completion
                    beat_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                beat_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the next state
    always_comb begin
        grant_owner_d = 2'b00;
        if (state_d == ST_GNT_I) grant_owner_d = 2'b01;
        if (state_d == ST_GNT_D) grant_owner_d = 2'b10;
        arb_busy_d = (state_d != ST_IDLE);
    end

    // FSM and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            last_grant_q  <= LG_I;
            grant_owner_q <= 2'b00;
            arb_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            last_grant_q  <= last_grant_d;
            grant_owner_q <= grant_owner_d;
            arb_busy_q    <= arb_busy_d;
        end
    end

    assign grant_owner = grant_owner_q;
    assign arb_busy    = arb_busy_q;

`ifdef ARB_STATS_EN
    logic [31:0] stat_i_grants_q, stat_i_grants_d;
    logic [31:0] stat_d_grants_q, stat_d_grants_d;
    logic [31:0] stat_conflicts_q, stat_conflicts_d;

    // Grant counts follow IDLE exits; conflicts are contested IDLE cycles
    always_comb begin
        stat_i_grants_d  = stat_i_grants_q;
        stat_d_grants_d  = stat_d_grants_q;
        stat_conflicts_d = stat_conflicts_q;
        if (state_q == ST_IDLE) begin
            if (state_d == ST_GNT_I) stat_i_grants_d = stat_i_grants_q + 32'd1;
            if (state_d == ST_GNT_D) stat_d_grants_d = stat_d_grants_q + 32'd1;
            if (i_req && d_req)      stat_conflicts_d = stat_conflicts_q + 32'd1;
        end
    end

    // Statistics counters, free-running with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_i_grants_q  <= 32'd0;
            stat_d_grants_q  <= 32'd0;
            stat_conflicts_q <= 32'd0;
        end else begin
            stat_i_grants_q  <= stat_i_grants_d;
            stat_d_grants_q  <= stat_d_grants_d;
            stat_conflicts_q <= stat_conflicts_d;
        end
    end

    assign stat_i_grants  = stat_i_grants_q;
    assign stat_d_grants  = stat_d_grants_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_arm7tdmi_cache_mem_arbiter.sv
// Testbench for arm7tdmi_cache_mem_arbiter: directed scenarios with fixed
// expectations plus a randomized run against a transaction-level model.
module tb_arm7tdmi_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic          i_req, i_lock, i_ready;
    logic          d_req, d_write, d_lock, d_ready;
    logic [31:0]   i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic [3:0]    d_byte_en, mem_byte_en;
    logic          mem_req, mem_write, mem_ready;
    logic [1:0]    grant_owner;
    logic          arb_busy;
`ifdef ARB_STATS_EN
    logic [31:0]   stat_i_grants, stat_d_grants, stat_conflicts;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    arm7tdmi_cache_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_req(i_req), .i_lock(i_lock),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_addr(d_addr), .d_req(d_req), .d_write(d_write), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_lock(d_lock),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_owner(grant_owner), .arb_busy(arb_busy)
`ifdef ARB_STATS_EN
        , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    // ---------------- transaction-level reference model ----------------
    // owner: 0 none, 1 icache, 2 dcache; last: who finished a beat last
    int m_owner, m_beats, m_last;
`ifdef ARB_STATS_EN
    int unsigned ms_i, ms_d, ms_c;
`endif

    logic          exp_req, exp_write, exp_i_ready, exp_d_ready, exp_busy;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;
    logic [3:0]    exp_be;
    logic [1:0]    exp_go;

    always_comb begin
        exp_req = 1'b0; exp_addr = '0; exp_write = 1'b0; exp_wdata = 32'd0; exp_be = 4'd0;
        if (m_owner == 1) begin
            exp_req = i_req; exp_addr = i_addr; exp_be = 4'hF;
        end else if (m_owner == 2) begin
            exp_req = d_req; exp_addr = d_addr; exp_write = d_write;
            exp_wdata = d_wdata; exp_be = d_byte_en;
        end
        exp_i_ready = (m_owner == 1) && exp_req && mem_ready;
        exp_d_ready = (m_owner == 2) && exp_req && mem_ready;
        exp_go      = 2'(m_owner);
        exp_busy    = (m_owner != 0);
    end

    task automatic model_reset();
        m_owner = 0; m_beats = 0; m_last = 1;
`ifdef ARB_STATS_EN
        ms_i = 0; ms_d = 0; ms_c = 0;
`endif
    endtask

    function automatic void model_step();
        logic req, lock;
        if (m_owner == 0) begin
            if (i_req && d_req) begin
                m_owner = (m_last == 1) ? 2 : 1;
`ifdef ARB_STATS_EN
                ms_c++;
`endif
            end else if (i_req) m_owner = 1;
            else if (d_req)     m_owner = 2;
`ifdef ARB_STATS_EN
            if (m_owner == 1) ms_i++;
            if (m_owner == 2) ms_d++;
`endif
        end else begin
            req  = (m_owner == 1) ? i_req  : d_req;
            lock = (m_owner == 1) ? i_lock : d_lock;
            if (!req) begin
                m_owner = 0; m_beats = 0;
            end else if (mem_ready) begin
                m_beats++;
                m_last = m_owner;
                if (!(lock && m_beats < MB)) begin
                    m_owner = 0; m_beats = 0;
                end
            end
        end
    endfunction

    // one clock: model follows the DUT edge, returns at the next falling edge
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_addr = '0; i_req = 0; i_lock = 0;
        d_addr = '0; d_req = 0; d_write = 0; d_wdata = 0; d_byte_en = 0; d_lock = 0;
        mem_rdata = 0; mem_ready = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0; model_reset();
        i_req = 1; d_req = 1; d_write = 1; d_byte_en = 4'hF; d_wdata = 32'h1234_5678;
        mem_ready = 1; mem_rdata = $urandom;
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if ({mem_req, mem_write, i_ready, d_ready, arb_busy} !== 5'b0) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_write, i_ready, d_ready, arb_busy}); end
        tests_run++; if ({mem_addr, mem_wdata, mem_byte_en, grant_owner} !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, mem_byte_en, grant_owner}); end
        tests_run++; if (i_rdata !== mem_rdata || d_rdata !== mem_rdata) begin tests_failed++; $display("FAIL rdata_bcast: got %h/%h expected %h", i_rdata, d_rdata, mem_rdata); end
        idle_inputs(); rst_n = 1;
        cycle();
        $display("[TB] reset checked");
    endtask

    task automatic test_conflict();
        for (int pair = 0; pair < 2; pair++) begin
            i_addr = 32'h2000; d_addr = 32'h1000; i_req = 1; d_req = 1; mem_ready = 1;
            #1;
            tests_run++; if (mem_req !== 1'b0 || grant_owner !== 2'b00) begin tests_failed++; $display("FAIL conflict_idle%0d: got req=%b owner=%b expected 0/00", pair, mem_req, grant_owner); end
            cycle(); #1;
            tests_run++; if (grant_owner !== 2'b10 || d_ready !== 1'b1 || mem_addr !== 32'h1000) begin tests_failed++; $display("FAIL conflict_dfirst%0d: got owner=%b dready=%b addr=%h expected 10/1/1000", pair, grant_owner, d_ready, mem_addr); end
            cycle(); d_req = 0; #1;
            tests_run++; if (grant_owner !== 2'b00) begin tests_failed++; $display("FAIL conflict_bubble%0d: got owner=%b expected 00", pair, grant_owner); end
            cycle(); #1;
            tests_run++; if (grant_owner !== 2'b01 || i_ready !== 1'b1 || mem_addr !== 32'h2000) begin tests_failed++; $display("FAIL conflict_isecond%0d: got owner=%b iready=%b addr=%h expected 01/1/2000", pair, grant_owner, i_ready, mem_addr); end
            cycle(); i_req = 0;
            cycle();
            $display("[TB] conflict pair %0d served d then i", pair);
        end
        idle_inputs();
    endtask

    task automatic test_single_read();
        d_addr = 32'h1000; d_req = 1; mem_ready = 1; mem_rdata = $urandom;
        #1;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL read_latency: got mem_req=%b expected 0", mem_req); end
        cycle(); #1;
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000 || d_ready !== 1'b1 || i_ready !== 1'b0 || grant_owner !== 2'b10 || arb_busy !== 1'b1) begin tests_failed++; $display("FAIL read_beat: got req=%b addr=%h dr=%b ir=%b owner=%b busy=%b expected 1/1000/1/0/10/1", mem_req, mem_addr, d_ready, i_ready, grant_owner, arb_busy); end
        tests_run++; if (d_rdata !== mem_rdata) begin tests_failed++; $display("FAIL read_data: got %h expected %h", d_rdata, mem_rdata); end
        cycle(); d_req = 0; #1;
        tests_run++; if (grant_owner !== 2'b00 || d_ready !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL read_release: got owner=%b dr=%b req=%b expected 00/0/0", grant_owner, d_ready, mem_req); end
        cycle();
        idle_inputs();
        $display("[TB] single dcache read done");
    endtask

    task automatic test_lock_burst();
        int beats = 0;
        int done  = 0;
        d_req = 1; d_lock = 1; mem_ready = 1; d_addr = 32'h5000;
        cycle();
        i_req = 1; i_addr = 32'h6000;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (d_ready === 1'b1 && i_ready === 1'b0) beats++;
            cycle();
            d_addr = d_addr + 4;
        end
        #1;
        tests_run++; if (beats !== MB) begin tests_failed++; $display("FAIL lock_beats: got %0d expected %0d", beats, MB); end
        tests_run++; if (grant_owner !== 2'b00 || d_ready !== 1'b0 || arb_busy !== 1'b0) begin tests_failed++; $display("FAIL lock_release: got owner=%b dr=%b busy=%b expected 00/0/0", grant_owner, d_ready, arb_busy); end
        cycle(); #1;
        tests_run++; if (grant_owner !== 2'b01 || i_ready !== 1'b1) begin tests_failed++; $display("FAIL lock_handover: got owner=%b ir=%b expected 01/1", grant_owner, i_ready); end
        cycle(); i_req = 0;
        for (int k = 0; k < 10 && done < 2; k++) begin
            cycle(); #1;
            if (d_ready === 1'b1) done++;
        end
        cycle(); d_req = 0; d_lock = 0;
        tests_run++; if (done !== 2) begin tests_failed++; $display("FAIL lock_tail: got %0d beats expected 2", done); end
        cycle();
        idle_inputs();
        $display("[TB] locked burst of %0d beats then handover", beats);
    endtask

    task automatic test_write();
        d_req = 1; d_write = 1; d_wdata = 32'hDEADBEEF; d_byte_en = 4'b0011; d_addr = 32'h3000; mem_ready = 1;
        cycle(); #1;
        tests_run++; if (mem_write !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_byte_en !== 4'b0011) begin tests_failed++; $display("FAIL write_beat: got w=%b wd=%h be=%b expected 1/deadbeef/0011", mem_write, mem_wdata, mem_byte_en); end
        cycle(); d_req = 0;
        i_req = 1; i_addr = 32'h4000;
        cycle(); #1;
        tests_run++; if (mem_write !== 1'b0 || mem_wdata !== 32'd0 || mem_byte_en !== 4'b1111 || mem_addr !== 32'h4000) begin tests_failed++; $display("FAIL icache_beat: got w=%b wd=%h be=%b addr=%h expected 0/0/1111/4000", mem_write, mem_wdata, mem_byte_en, mem_addr); end
        cycle(); i_req = 0;
        cycle();
        idle_inputs();
        $display("[TB] write and icache beat shapes done");
    endtask

    task automatic test_reset_abort();
        d_req = 1; d_addr = 32'h7000; mem_ready = 0;
        cycle(); #1;
        tests_run++; if (grant_owner !== 2'b10 || mem_req !== 1'b1 || arb_busy !== 1'b1) begin tests_failed++; $display("FAIL abort_pre: got owner=%b req=%b busy=%b expected 10/1/1", grant_owner, mem_req, arb_busy); end
        rst_n = 0; model_reset(); #1;
        tests_run++; if (mem_req !== 1'b0 || arb_busy !== 1'b0 || grant_owner !== 2'b00 || d_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_async: got req=%b busy=%b owner=%b dr=%b expected 0/0/00/0", mem_req, arb_busy, grant_owner, d_ready); end
        cycle();
        rst_n = 1; mem_ready = 1;
        cycle(); #1;
        tests_run++; if (grant_owner !== 2'b10 || d_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_rearb: got owner=%b dr=%b expected 10/1", grant_owner, d_ready); end
        cycle(); d_req = 0;
        cycle();
        idle_inputs();
        $display("[TB] reset during grant handled");
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        rst_n = 0; model_reset(); idle_inputs();
        cycle(); rst_n = 1; cycle();
        for (int p = 0; p < 3; p++) begin
            i_req = 1; d_req = 1; mem_ready = 1; i_addr = 32'h2000; d_addr = 32'h1000;
            cycle(); cycle(); d_req = 0;
            cycle(); cycle(); i_req = 0;
            cycle();
        end
        #1;
        tests_run++; if (stat_conflicts !== 32'd3 || stat_i_grants !== 32'd3 || stat_d_grants !== 32'd3) begin tests_failed++; $display("FAIL stats_pairs: got c=%0d i=%0d d=%0d expected 3/3/3", stat_conflicts, stat_i_grants, stat_d_grants); end
        idle_inputs();
        $display("[TB] stats after 3 conflicting pairs");
    endtask
`endif

    task automatic test_random();
        logic [74:0] act, exp;
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            i_req = ($urandom_range(0, 3) != 0); d_req = ($urandom_range(0, 3) != 0);
            i_lock = $urandom_range(0, 1); d_lock = $urandom_range(0, 1);
            i_addr = $urandom; d_addr = $urandom; d_write = $urandom_range(0, 1);
            d_wdata = $urandom; d_byte_en = 4'($urandom); mem_rdata = $urandom;
            mem_ready = ($urandom_range(0, 2) != 0);
            #1;
            act = {mem_req, mem_addr, mem_write, mem_wdata, mem_byte_en, i_ready, d_ready, grant_owner, arb_busy};
            exp = {exp_req, exp_addr, exp_write, exp_wdata, exp_be, exp_i_ready, exp_d_ready, exp_go, exp_busy};
            tests_run++;
            if (act !== exp || i_rdata !== mem_rdata || d_rdata !== mem_rdata) begin
                tests_failed++; errs++;
                $display("FAIL random_c%0d: got %h expected %h", c, act, exp);
            end
            cycle();
        end
`ifdef ARB_STATS_EN
        #1;
        tests_run++; if (stat_i_grants !== ms_i || stat_d_grants !== ms_d || stat_conflicts !== ms_c) begin tests_failed++; $display("FAIL random_stats: got %0d/%0d/%0d expected %0d/%0d/%0d", stat_i_grants, stat_d_grants, stat_conflicts, ms_i, ms_d, ms_c); end
`endif
        idle_inputs();
        $display("[TB] random run of 400 cycles, %0d mismatching cycles", errs);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_conflict();
        test_single_read();
        test_lock_burst();
        test_write();
        test_reset_abort();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/arm7tdmi_cache_mem_arbiter.md
Name: arm7tdmi_cache_mem_arbiter

Overview:
Shares the single external memory port between the instruction-cache refill path and the data-cache refill/write-back path. It performs round-robin arbitration and holds the grant for the whole of each transaction. A requester can lock the grant for a bounded line-fill burst. The block sits between the two cache memory-side interfaces and the memory model/bus, and exposes grant status for the performance monitor.

Parameters:
ADDR_WIDTH, 32, address width of all address ports
MAX_BURST, 4, maximum beats a locked requester holds the grant before forced release (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_addr  in  ADDR_WIDTH  icache request address (read-only requester)
i_req  in  1  icache request; held high until i_ready
i_lock  in  1  icache asks to keep the grant after the current beat
i_rdata  out  32  read data to icache
i_ready  out  1  icache beat complete
d_addr  in  ADDR_WIDTH  dcache request address
d_req  in  1  dcache request; held high until d_ready
d_write  in  1  dcache write (write-back) when 1
d_wdata  in  32  dcache write data
d_byte_en  in  4  dcache byte enables
d_lock  in  1  dcache asks to keep the grant after the current beat
d_rdata  out  32  read data to dcache
d_ready  out  1  dcache beat complete
mem_addr  out  ADDR_WIDTH  memory address
mem_req  out  1  memory request
mem_write  out  1  memory write
mem_wdata  out  32  memory write data
mem_byte_en  out  4  memory byte enables
mem_rdata  in  32  memory read data
mem_ready  in  1  memory beat complete
grant_owner  out  2  00 none, 01 icache, 10 dcache (registered)
arb_busy  out  1  1 when the FSM is not IDLE

Behaviour:
- Reset (async, rst_n low): FSM=IDLE, beat_cnt=0, last_grant=I, so the dcache wins the first tie. All outputs are 0 except i_rdata/d_rdata.
- i_rdata and d_rdata are always mem_rdata, a combinational broadcast. Consumers qualify with ready.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Only i_req high -> GNT_I.
  - Only d_req high -> GNT_D.
  - Both high -> grant the requester that is not last_grant.
  - Neither high -> stay in IDLE.
  - Arbitration latency is 1 cycle: mem_req rises the cycle after the request is seen in IDLE.
- GNT_x datapath:
  - mem_req = x_req, mem_addr = x_addr.
  - For D: mem_write = d_write, mem_wdata = d_wdata, mem_byte_en = d_byte_en.
  - For I: mem_write=0, mem_wdata=0, mem_byte_en=4'b1111.
  - x_ready = mem_ready & mem_req. The non-granted ready is 0.
- Beat completes when mem_req & mem_ready. On completion:
  - beat_cnt++ and last_grant := x.
  - If x_lock=1 and beat_cnt+1 < MAX_BURST: stay in GNT_x.
  - Otherwise: beat_cnt := 0 and go to IDLE.
- Unlocked transactions therefore insert one IDLE bubble. Forced release at MAX_BURST lets a pending other requester win in IDLE via round-robin.
- Abort: x_req low while in GNT_x with no completion -> IDLE next cycle, beat_cnt := 0, last_grant unchanged.
- mem_ready while mem_req=0 is ignored.
- In IDLE, mem_* outputs are 0 regardless of requester inputs.
- Lock raised in IDLE without a request has no effect. Lock is sampled only at beat completion.
- grant_owner and arb_busy are registered and reflect the current state.
- Reset asserted mid-burst: outputs drop to 0 immediately (async). The requester sees no ready for the aborted beat.

Optional Feature:
ARB_STATS_EN.
- When defined, adds three 32-bit outputs:
  - stat_i_grants: IDLE->GNT_I transitions.
  - stat_d_grants: IDLE->GNT_D transitions.
  - stat_conflicts: IDLE cycles with both i_req and d_req high.
- All three counters reset to 0, wrap at 2^32, and feed the cache performance monitor.
- When undefined, these ports and counters do not exist.

Test Plan:
- Single dcache read d_addr=0x1000, mem_ready=1: mem_req rises 1 cycle after d_req; mem_addr=0x1000; d_ready pulses 1 cycle; grant_owner goes 10 then 00.
- Simultaneous i_req (0x2000) and d_req (0x1000) after reset: dcache is served first, then icache. Next simultaneous pair: dcache first again (last_grant=I).
- d_lock=1 with 6 back-to-back beats, i_req pending, MAX_BURST=4: exactly 4 contiguous d_ready beats, then one IDLE cycle, then icache granted.
- Dcache write d_wdata=0xDEADBEEF, d_byte_en=4'b0011: mem_write=1, mem_wdata=0xDEADBEEF, mem_byte_en=0011. An icache beat drives mem_write=0, mem_byte_en=1111.
- Reset pulsed during GNT_D with mem_ready=0: mem_req=0, arb_busy=0, grant_owner=00 immediately. After release the FSM re-arbitrates from IDLE.
- ARB_STATS_EN defined, 3 conflicting pairs: stat_conflicts=3, stat_i_grants=3, stat_d_grants=3.
